// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// LDM opcode field and default widths.
package fetch_controller_pkg;

    localparam int unsigned NUM_OF_BITS_DEF      = 16;
    localparam int unsigned PC_WIDTH_DEF         = 32;
    localparam int unsigned NUM_OF_REGISTERS_DEF = 5;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] LDM_OPCODE_DEF = 5'h19;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_FETCH = 2'd1,
        ST_IMM   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Fetch sequencer: issues instruction-memory addresses, absorbs the one-cycle
// registered read, merges LDM + immediate into one registered fetch packet.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned       Num_of_bits      = NUM_OF_BITS_DEF,
    parameter int unsigned       pc_width         = PC_WIDTH_DEF,
    parameter int unsigned       Num_of_registers = NUM_OF_REGISTERS_DEF,
    parameter logic [31:0]       RESET_PC         = 32'd0,
    parameter logic [OPC_W-1:0]  LDM_OPCODE       = LDM_OPCODE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [pc_width-1:0]    flush_pc,
    output logic [pc_width-1:0]    mem_addr,
    output logic                   cs_ldm,
    input  logic [Num_of_bits-1:0] mem_data,
    output logic                   if_valid,
    output logic [Num_of_bits-1:0] if_instr,
    output logic [Num_of_bits-1:0] if_imm,
    output logic                   if_has_imm,
    output logic [pc_width-1:0]    if_pc
);

    localparam int unsigned AW = Num_of_registers;
    typedef logic [AW-1:0] addr_t;

    localparam addr_t RESET_ADDR = RESET_PC[AW-1:0];

    fetch_state_t           state_q, state_d;
    addr_t                  pc_q, pc_d;
    addr_t                  word_pc_q, word_pc_d;
    addr_t                  instr_pc_q, instr_pc_d;
    logic [Num_of_bits-1:0] instr_q, instr_d;

    logic                   valid_d, has_imm_d;
    logic [Num_of_bits-1:0] out_instr_d, out_imm_d;
    logic [pc_width-1:0]    out_pc_d;

    addr_t flush_addr;
    logic  is_ldm;
    logic  hold;
    logic  unused_flush_hi;

    // Addresses live modulo the memory depth; the upper redirect bits are dropped.
    assign flush_addr      = flush_pc[AW-1:0];
    assign unused_flush_hi = ^flush_pc[pc_width-1:AW];
    assign is_ldm          = (mem_data[OPC_MSB:OPC_LSB] == LDM_OPCODE);
    assign hold            = stall && (state_q != ST_PRIME);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FETCH;
        end else if (!hold) begin
            unique case (state_q)
                ST_PRIME: state_d = ST_FETCH;
                ST_FETCH: state_d = is_ldm ? ST_IMM : ST_FETCH;
                ST_IMM:   state_d = ST_FETCH;
                default:  state_d = ST_PRIME;
            endcase
        end
    end

    // Memory address mux, LDM strobe and next values of the fetch datapath.
    always_comb begin
        mem_addr    = pc_width'(pc_q);
        cs_ldm      = (state_q == ST_IMM);
        pc_d        = pc_q;
        word_pc_d   = word_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = if_valid;
        has_imm_d   = if_has_imm;
        out_instr_d = if_instr;
        out_imm_d   = if_imm;
        out_pc_d    = if_pc;

        if (flush) begin
            mem_addr  = pc_width'(flush_addr);
            word_pc_d = flush_addr;
            pc_d      = flush_addr + addr_t'(1);
            valid_d   = 1'b0;
            has_imm_d = 1'b0;
        end else if (hold) begin
            // Replay the current word so mem_data stays stable while stalled.
            mem_addr = pc_width'(word_pc_q);
        end else begin
            word_pc_d = pc_q;
            pc_d      = pc_q + addr_t'(1);
            unique case (state_q)
                ST_PRIME: valid_d = 1'b0;
                ST_FETCH: begin
                    if (is_ldm) begin
                        instr_d    = mem_data;
                        instr_pc_d = word_pc_q;
                        valid_d    = 1'b0;
                    end else begin
                        out_instr_d = mem_data;
                        out_imm_d   = '0;
                        out_pc_d    = pc_width'(word_pc_q);
                        has_imm_d   = 1'b0;
                        valid_d     = 1'b1;
                    end
                end
                ST_IMM: begin
                    out_instr_d = instr_q;
                    out_imm_d   = mem_data;
                    out_pc_d    = pc_width'(instr_pc_q);
                    has_imm_d   = 1'b1;
                    valid_d     = 1'b1;
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            word_pc_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_imm     <= '0;
            if_has_imm <= 1'b0;
            if_pc      <= '0;
        end else begin
            pc_q       <= pc_d;
            word_pc_q  <= word_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            if_valid   <= valid_d;
            if_instr   <= out_instr_d;
            if_imm     <= out_imm_d;
            if_has_imm <= has_imm_d;
            if_pc      <= out_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a 32-word registered-read memory model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] flush_pc;
    logic [31:0] mem_addr;
    logic        cs_ldm;
    logic [15:0] mem_data;
    logic        if_valid;
    logic [15:0] if_instr, if_imm;
    logic        if_has_imm;
    logic [31:0] if_pc;

    logic [15:0] mem [32];
    int          n_vec = 0;
    int          n_err = 0;

    fetch_controller dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .mem_addr   (mem_addr),
        .cs_ldm     (cs_ldm),
        .mem_data   (mem_data),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_imm     (if_imm),
        .if_has_imm (if_has_imm),
        .if_pc      (if_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[mem_addr[4:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                       input logic has_imm, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(if_valid), 32'd1);
        chk({tag, ".instr"}, 32'(if_instr), 32'(instr));
        chk({tag, ".imm"}, 32'(if_imm), 32'(imm));
        chk({tag, ".has_imm"}, 32'(if_has_imm), 32'(has_imm));
        chk({tag, ".pc"}, if_pc, pc);
    endtask

    task automatic bubble(input string tag, input logic ldm);
        chk({tag, ".valid"}, 32'(if_valid), 32'd0);
        chk({tag, ".cs_ldm"}, 32'(cs_ldm), 32'(ldm));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h4000 + 16'(i);
        mem[0]  = 16'h0801; mem[1] = 16'h1002; mem[2] = 16'h1803; mem[3] = 16'h2004;
        mem[4]  = 16'hC812; mem[5] = 16'hBEEF; mem[6] = 16'h3006; mem[7] = 16'hC8AA;
        mem[8]  = 16'h1234;
        mem[20] = 16'h5014; mem[21] = 16'h5015; mem[31] = 16'h7F1F;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        tick(); tick();
        chk("rst.valid", 32'(if_valid), 32'd0);
        chk("rst.instr", 32'(if_instr), 32'd0);
        chk("rst.imm", 32'(if_imm), 32'd0);
        chk("rst.has_imm", 32'(if_has_imm), 32'd0);
        chk("rst.pc", if_pc, 32'd0);
        chk("rst.cs_ldm", 32'(cs_ldm), 32'd0);

        // Straight-line fetch
        rst = 1'b0; #1;
        chk("prime.addr", mem_addr, 32'd0);
        tick(); bubble("prime", 1'b0);
        chk("fetch1.addr", mem_addr, 32'd1);
        tick(); pkt("pc0", 16'h0801, 16'h0, 1'b0, 32'd0);
        tick(); pkt("pc1", 16'h1002, 16'h0, 1'b0, 32'd1);
        tick(); pkt("pc2", 16'h1803, 16'h0, 1'b0, 32'd2);

        // Stall while pc2 packet is valid
        stall = 1'b1; #1;
        chk("stall.addr", mem_addr, 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick(); pkt("stall.hold", 16'h1803, 16'h0, 1'b0, 32'd2);
            chk("stall.addr_hold", mem_addr, 32'd3);
        end
        stall = 1'b0; #1;
        chk("unstall.addr", mem_addr, 32'd4);
        tick(); pkt("pc3", 16'h2004, 16'h0, 1'b0, 32'd3);

        // LDM at 4 with stall during IMM
        tick(); bubble("ldm4.bubble", 1'b1);
        chk("ldm4.addr", mem_addr, 32'd6);
        stall = 1'b1; #1;
        chk("ldm4.stall_addr", mem_addr, 32'd5);
        tick(); bubble("ldm4.stall1", 1'b1);
        tick(); bubble("ldm4.stall2", 1'b1);
        stall = 1'b0;
        tick(); pkt("ldm4", 16'hC812, 16'hBEEF, 1'b1, 32'd4);
        tick(); pkt("pc6", 16'h3006, 16'h0, 1'b0, 32'd6);

        // Flush while in IMM: held LDM at 7 dropped, upper bits truncated
        tick(); bubble("ldm7.bubble", 1'b1);
        flush = 1'b1; flush_pc = 32'hFFFF_FFF4; #1;
        chk("flush.addr", mem_addr, 32'd20);
        tick();
        flush = 1'b0; #1;
        bubble("flush.bubble", 1'b0);
        chk("flush.has_imm", 32'(if_has_imm), 32'd0);
        chk("flush.next_addr", mem_addr, 32'd21);
        tick(); pkt("pc20", 16'h5014, 16'h0, 1'b0, 32'd20);
        tick(); pkt("pc21", 16'h5015, 16'h0, 1'b0, 32'd21);

        // Flush and stall together: flush wins
        flush = 1'b1; stall = 1'b1; flush_pc = 32'd10; #1;
        chk("flushstall.addr", mem_addr, 32'd10);
        tick();
        flush = 1'b0; stall = 1'b0; #1;
        bubble("flushstall.bubble", 1'b0);
        tick(); pkt("pc10", 16'h400A, 16'h0, 1'b0, 32'd10);

        // Wrap of a one-word instruction at 31
        flush = 1'b1; flush_pc = 32'd31;
        tick();
        flush = 1'b0; #1;
        chk("wrap.addr", mem_addr, 32'd0);
        tick(); pkt("pc31", 16'h7F1F, 16'h0, 1'b0, 32'd31);
        tick(); pkt("wrap.pc0", 16'h0801, 16'h0, 1'b0, 32'd0);

        // LDM at 31 takes its immediate from address 0
        mem[31] = 16'hC91F;
        flush = 1'b1; flush_pc = 32'd31;
        tick();
        flush = 1'b0;
        tick(); bubble("ldm31.bubble", 1'b1);
        tick(); pkt("ldm31", 16'hC91F, 16'h0801, 1'b1, 32'd31);

        // Reset while in IMM with flush asserted
        flush = 1'b1; flush_pc = 32'd4;
        tick();
        flush = 1'b0;
        tick(); bubble("ldm_rst.bubble", 1'b1);
        rst = 1'b1; flush = 1'b1; flush_pc = 32'd20;
        tick();
        chk("rst2.valid", 32'(if_valid), 32'd0);
        chk("rst2.instr", 32'(if_instr), 32'd0);
        chk("rst2.imm", 32'(if_imm), 32'd0);
        chk("rst2.has_imm", 32'(if_has_imm), 32'd0);
        chk("rst2.pc", if_pc, 32'd0);
        chk("rst2.cs_ldm", 32'(cs_ldm), 32'd0);
        rst = 1'b0; flush = 1'b0; #1;
        chk("rst2.addr", mem_addr, 32'd0);
        tick(); bubble("rst2.prime", 1'b0);
        tick(); pkt("rst2.pc0", 16'h0801, 16'h0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
